// File: rtl/sinfonia_pkg.sv
// Shared state encoding, strobe bundle and default sizing for the Sinfonia controller.
// decodifica() maps each state to its Moore strobes. The message-wrap clear is added by the controller.
package sinfonia_pkg;

    localparam int MAX_ERROS_PAD  = 3;
    localparam int MSG_PASSOS_PAD = 21;
    localparam int DISP_DIV_PAD   = 4;

    typedef enum logic [4:0] {
        INICIAL         = 5'd0,
        MENSAGEM        = 5'd1,
        AVANCA_MSG      = 5'd2,
        REGISTRA_MUSICA = 5'd3,
        PREPARA_RODADA  = 5'd4,
        TOCA_NOTA       = 5'd5,
        PROXIMA_NOTA    = 5'd6,
        FIM_MOSTRA      = 5'd7,
        ESPERA_JOGADA   = 5'd8,
        REGISTRA        = 5'd9,
        COMPARA         = 5'd10,
        PROXIMA_JOGADA  = 5'd11,
        ERRO            = 5'd12,
        FIM_RODADA      = 5'd13,
        PROXIMA_RODADA  = 5'd14,
        FIM_JOGO        = 5'd15
    } estado_t;

    typedef struct packed {
        logic zera_contador_rodada;
        logic zera_contador_jogada;
        logic zera_registrador_botoes;
        logic zeraErro;
        logic zeraPontos;
        logic zera_timer_msg;
        logic zera_contador_msg;
        logic zera_timeout_buzzer;
        logic zeraT;
        logic enable_contador_rodada;
        logic enable_contador_jogada;
        logic enable_registrador_botoes;
        logic enable_registrador_musica;
        logic enable_timer_msg;
        logic enable_contador_msg;
        logic conta_timeout_buzzer;
        logic contaT;
        logic contaErro;
        logic regPontos;
        logic calcular;
        logic mostraJ;
        logic mostraB;
        logic select_letra;
        logic sel_memoria_arduino;
        logic activateArduino;
    } saidas_t;

    function automatic saidas_t decodifica(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            INICIAL: begin
                s.zera_contador_rodada    = 1'b1;
                s.zera_contador_jogada    = 1'b1;
                s.zera_registrador_botoes = 1'b1;
                s.zeraErro                = 1'b1;
                s.zeraPontos              = 1'b1;
                s.zera_timer_msg          = 1'b1;
                s.zera_contador_msg       = 1'b1;
                s.zera_timeout_buzzer     = 1'b1;
            end
            MENSAGEM:        s.enable_timer_msg = 1'b1;
            AVANCA_MSG: begin
                s.enable_contador_msg = 1'b1;
                s.zera_timer_msg      = 1'b1;
            end
            REGISTRA_MUSICA: s.enable_registrador_musica = 1'b1;
            PREPARA_RODADA: begin
                s.zera_contador_jogada = 1'b1;
                s.zeraErro             = 1'b1;
                s.zera_timeout_buzzer  = 1'b1;
            end
            TOCA_NOTA: begin
                s.mostraJ              = 1'b1;
                s.sel_memoria_arduino  = 1'b1;
                s.activateArduino      = 1'b1;
                s.conta_timeout_buzzer = 1'b1;
                s.select_letra         = 1'b1;
            end
            PROXIMA_NOTA: begin
                s.enable_contador_jogada = 1'b1;
                s.zera_timeout_buzzer    = 1'b1;
            end
            FIM_MOSTRA: begin
                s.zera_contador_jogada    = 1'b1;
                s.zera_registrador_botoes = 1'b1;
                s.zeraT                   = 1'b1;
            end
            ESPERA_JOGADA: begin
                s.mostraB         = 1'b1;
                s.activateArduino = 1'b1;
                s.select_letra    = 1'b1;
                s.contaT          = 1'b1;
            end
            REGISTRA: begin
                s.enable_registrador_botoes = 1'b1;
                s.zeraT                     = 1'b1;
            end
            PROXIMA_JOGADA:  s.enable_contador_jogada = 1'b1;
            ERRO:            s.contaErro = 1'b1;
            FIM_RODADA: begin
                s.calcular  = 1'b1;
                s.regPontos = 1'b1;
            end
            PROXIMA_RODADA:  s.enable_contador_rodada = 1'b1;
            FIM_JOGO:        s.mostraB = 1'b1;
            default:         s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_sinfonia.sv
// Moore sequencer for the Sinfonia datapath. Strobes are registered from the next state, so they change with the state register.
// Each state lasts one cycle unless it waits on a datapath flag. The display digit index runs free in every state.
module unidade_controle_sinfonia
    import sinfonia_pkg::*;
#(
    parameter int MAX_ERROS  = MAX_ERROS_PAD,
    parameter int MSG_PASSOS = MSG_PASSOS_PAD,
    parameter int DISP_DIV   = DISP_DIV_PAD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       botoesIgualMemoria,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    input  logic       muda_nota,
    input  logic       timeout_contador_msg,
    output logic       zera_contador_rodada,
    output logic       zera_contador_jogada,
    output logic       zera_registrador_botoes,
    output logic       zeraErro,
    output logic       zeraPontos,
    output logic       zera_timer_msg,
    output logic       zera_contador_msg,
    output logic       zera_timeout_buzzer,
    output logic       zeraT,
    output logic       enable_contador_rodada,
    output logic       enable_contador_jogada,
    output logic       enable_registrador_botoes,
    output logic       enable_registrador_musica,
    output logic       enable_timer_msg,
    output logic       enable_contador_msg,
    output logic       conta_timeout_buzzer,
    output logic       contaT,
    output logic       contaErro,
    output logic       regPontos,
    output logic       calcular,
    output logic       mostraJ,
    output logic       mostraB,
    output logic       select_letra,
    output logic       sel_memoria_arduino,
    output logic       activateArduino,
    output logic [1:0] contagem_display,
    output logic [4:0] db_estado
);

    localparam int W_ERR  = $clog2(MAX_ERROS + 1);
    localparam int W_PASS = $clog2(MSG_PASSOS + 1);
    localparam int W_DIV  = $clog2(DISP_DIV + 1);
    localparam logic [W_ERR-1:0]  ERR_MAX    = W_ERR'(MAX_ERROS);
    localparam logic [W_PASS-1:0] PASSOS_FIM = W_PASS'(MSG_PASSOS - 1);
    localparam logic [W_DIV-1:0]  DIV_FIM    = W_DIV'(DISP_DIV - 1);

    estado_t           r_estado;
    estado_t           w_prox;
    saidas_t           r_saida;
    saidas_t           w_saida;
    logic [W_ERR-1:0]  r_erros;
    logic [W_PASS-1:0] r_passos;
    logic [W_DIV-1:0]  r_div;
    logic [1:0]        r_disp;
    logic              w_passo_fim;

    assign w_passo_fim = (r_passos == PASSOS_FIM);

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:         if (iniciar) w_prox = MENSAGEM;
            MENSAGEM: begin
                if (tem_jogada)                w_prox = REGISTRA_MUSICA;
                else if (timeout_contador_msg) w_prox = AVANCA_MSG;
            end
            AVANCA_MSG:      w_prox = tem_jogada ? REGISTRA_MUSICA : MENSAGEM;
            REGISTRA_MUSICA: w_prox = PREPARA_RODADA;
            PREPARA_RODADA:  w_prox = TOCA_NOTA;
            TOCA_NOTA:       if (muda_nota) w_prox = enderecoIgualLimite ? FIM_MOSTRA : PROXIMA_NOTA;
            PROXIMA_NOTA:    w_prox = TOCA_NOTA;
            FIM_MOSTRA:      w_prox = ESPERA_JOGADA;
            ESPERA_JOGADA:   if (tem_jogada) w_prox = REGISTRA;
            REGISTRA:        w_prox = COMPARA;
            COMPARA: begin
                if (!botoesIgualMemoria)      w_prox = ERRO;
                else if (enderecoIgualLimite) w_prox = FIM_RODADA;
                else                          w_prox = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA:  w_prox = ESPERA_JOGADA;
            ERRO:            w_prox = (r_erros == ERR_MAX) ? FIM_JOGO : ESPERA_JOGADA;
            FIM_RODADA:      w_prox = fimL ? FIM_JOGO : PROXIMA_RODADA;
            PROXIMA_RODADA:  w_prox = PREPARA_RODADA;
            FIM_JOGO:        if (iniciar) w_prox = INICIAL;
            default:         w_prox = INICIAL;
        endcase
    end

    // The last scroll step also rewinds the message counter in the datapath.
    always_comb begin
        w_saida = decodifica(w_prox);
        if (w_prox == AVANCA_MSG && w_passo_fim)
            w_saida.zera_contador_msg = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
            r_saida  <= decodifica(INICIAL);
            r_erros  <= '0;
            r_passos <= '0;
        end else begin
            r_estado <= w_prox;
            r_saida  <= w_saida;
            if (w_prox == INICIAL || w_prox == PREPARA_RODADA)
                r_erros <= '0;
            else if (w_prox == ERRO && r_erros != ERR_MAX)
                r_erros <= r_erros + 1'b1;
            if (w_prox == INICIAL)
                r_passos <= '0;
            else if (w_prox == AVANCA_MSG)
                r_passos <= w_passo_fim ? '0 : r_passos + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_disp <= '0;
        end else if (r_div == DIV_FIM) begin
            r_div  <= '0;
            r_disp <= r_disp + 1'b1;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    assign zera_contador_rodada      = r_saida.zera_contador_rodada;
    assign zera_contador_jogada      = r_saida.zera_contador_jogada;
    assign zera_registrador_botoes   = r_saida.zera_registrador_botoes;
    assign zeraErro                  = r_saida.zeraErro;
    assign zeraPontos                = r_saida.zeraPontos;
    assign zera_timer_msg            = r_saida.zera_timer_msg;
    assign zera_contador_msg         = r_saida.zera_contador_msg;
    assign zera_timeout_buzzer       = r_saida.zera_timeout_buzzer;
    assign zeraT                     = r_saida.zeraT;
    assign enable_contador_rodada    = r_saida.enable_contador_rodada;
    assign enable_contador_jogada    = r_saida.enable_contador_jogada;
    assign enable_registrador_botoes = r_saida.enable_registrador_botoes;
    assign enable_registrador_musica = r_saida.enable_registrador_musica;
    assign enable_timer_msg          = r_saida.enable_timer_msg;
    assign enable_contador_msg       = r_saida.enable_contador_msg;
    assign conta_timeout_buzzer      = r_saida.conta_timeout_buzzer;
    assign contaT                    = r_saida.contaT;
    assign contaErro                 = r_saida.contaErro;
    assign regPontos                 = r_saida.regPontos;
    assign calcular                  = r_saida.calcular;
    assign mostraJ                   = r_saida.mostraJ;
    assign mostraB                   = r_saida.mostraB;
    assign select_letra              = r_saida.select_letra;
    assign sel_memoria_arduino       = r_saida.sel_memoria_arduino;
    assign activateArduino           = r_saida.activateArduino;
    assign contagem_display          = r_disp;
    assign db_estado                 = r_estado;

endmodule

// File: tb/tb_unidade_controle_sinfonia.sv
// Directed walk through the Sinfonia controller: message scroll, two games, error limit and mid-game reset.
module tb_unidade_controle_sinfonia;

    logic clock, reset, iniciar, tem_jogada, botoesIgualMemoria, enderecoIgualLimite;
    logic fimL, muda_nota, timeout_contador_msg;
    logic zera_contador_rodada, zera_contador_jogada, zera_registrador_botoes, zeraErro, zeraPontos;
    logic zera_timer_msg, zera_contador_msg, zera_timeout_buzzer, zeraT;
    logic enable_contador_rodada, enable_contador_jogada, enable_registrador_botoes;
    logic enable_registrador_musica, enable_timer_msg, enable_contador_msg;
    logic conta_timeout_buzzer, contaT, contaErro, regPontos, calcular;
    logic mostraJ, mostraB, select_letra, sel_memoria_arduino, activateArduino;
    logic [1:0] contagem_display;
    logic [4:0] db_estado;

    int checks = 0;
    int failures = 0;

    unidade_controle_sinfonia #(.MAX_ERROS(3), .MSG_PASSOS(3), .DISP_DIV(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
        .botoesIgualMemoria(botoesIgualMemoria), .enderecoIgualLimite(enderecoIgualLimite),
        .fimL(fimL), .muda_nota(muda_nota), .timeout_contador_msg(timeout_contador_msg),
        .zera_contador_rodada(zera_contador_rodada), .zera_contador_jogada(zera_contador_jogada),
        .zera_registrador_botoes(zera_registrador_botoes), .zeraErro(zeraErro), .zeraPontos(zeraPontos),
        .zera_timer_msg(zera_timer_msg), .zera_contador_msg(zera_contador_msg),
        .zera_timeout_buzzer(zera_timeout_buzzer), .zeraT(zeraT),
        .enable_contador_rodada(enable_contador_rodada), .enable_contador_jogada(enable_contador_jogada),
        .enable_registrador_botoes(enable_registrador_botoes),
        .enable_registrador_musica(enable_registrador_musica), .enable_timer_msg(enable_timer_msg),
        .enable_contador_msg(enable_contador_msg), .conta_timeout_buzzer(conta_timeout_buzzer),
        .contaT(contaT), .contaErro(contaErro), .regPontos(regPontos), .calcular(calcular),
        .mostraJ(mostraJ), .mostraB(mostraB), .select_letra(select_letra),
        .sel_memoria_arduino(sel_memoria_arduino), .activateArduino(activateArduino),
        .contagem_display(contagem_display), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0; botoesIgualMemoria = 1'b0;
        enderecoIgualLimite = 1'b0; fimL = 1'b0; muda_nota = 1'b0; timeout_contador_msg = 1'b0;
        #1;
        chk("rst_estado", db_estado, 0);
        chk("rst_zera_rodada", zera_contador_rodada, 1);
        chk("rst_zeraPontos", zeraPontos, 1);
        chk("rst_zera_cmsg", zera_contador_msg, 1);
        chk("rst_zeraT", zeraT, 0);
        chk("rst_display", contagem_display, 0);
        #2 reset = 1'b0; iniciar = 1'b1;

        // Message scroll with wrap after 3 steps
        step(); chk("mensagem", db_estado, 1); chk("en_timer_msg", enable_timer_msg, 1);
        chk("sel_letra_msg", select_letra, 0);
        iniciar = 1'b0; timeout_contador_msg = 1'b1;
        step(); chk("avanca1", db_estado, 2); chk("en_cmsg1", enable_contador_msg, 1);
        chk("zera_tmsg1", zera_timer_msg, 1); chk("zera_cmsg1", zera_contador_msg, 0);
        timeout_contador_msg = 1'b0;
        step(); chk("volta_msg", db_estado, 1); chk("en_cmsg_off", enable_contador_msg, 0);
        step(); chk("espera_msg", db_estado, 1); chk("en_cmsg_idle", enable_contador_msg, 0);
        timeout_contador_msg = 1'b1;
        step(); chk("avanca2", db_estado, 2); chk("zera_cmsg2", zera_contador_msg, 0);
        timeout_contador_msg = 1'b0;
        step();
        timeout_contador_msg = 1'b1;
        step(); chk("avanca3", db_estado, 2); chk("zera_cmsg_wrap", zera_contador_msg, 1);
        timeout_contador_msg = 1'b0;
        step(); chk("volta_msg3", db_estado, 1);

        // tem_jogada wins over timeout
        tem_jogada = 1'b1; timeout_contador_msg = 1'b1;
        step(); chk("reg_musica", db_estado, 3); chk("en_musica", enable_registrador_musica, 1);
        tem_jogada = 1'b0; timeout_contador_msg = 1'b0;
        step(); chk("prepara", db_estado, 4); chk("en_musica_off", enable_registrador_musica, 0);
        chk("zeraErro_prep", zeraErro, 1);
        step(); chk("toca", db_estado, 5); chk("mostraJ", mostraJ, 1); chk("arduino", activateArduino, 1);

        // Round 0: single note, match
        enderecoIgualLimite = 1'b1;
        step(); chk("toca_hold", db_estado, 5);
        muda_nota = 1'b1;
        step(); chk("fim_mostra", db_estado, 7); chk("zeraT_fm", zeraT, 1);
        muda_nota = 1'b0;
        step(); chk("espera", db_estado, 8); chk("contaT", contaT, 1); chk("mostraB_esp", mostraB, 1);
        tem_jogada = 1'b1;
        step(); chk("registra", db_estado, 9); chk("en_botoes", enable_registrador_botoes, 1);
        tem_jogada = 1'b0; botoesIgualMemoria = 1'b1;
        step(); chk("compara", db_estado, 10); chk("en_botoes_off", enable_registrador_botoes, 0);
        step(); chk("fim_rodada", db_estado, 13); chk("calcular", calcular, 1); chk("regPontos", regPontos, 1);
        step(); chk("prox_rodada", db_estado, 14); chk("calcular_off", calcular, 0);
        chk("regPontos_off", regPontos, 0); chk("en_rodada", enable_contador_rodada, 1);
        step(); chk("prepara2", db_estado, 4);
        step(); chk("toca2", db_estado, 5);

        // Round 1: two notes, one correct play, then three errors
        enderecoIgualLimite = 1'b0; muda_nota = 1'b1;
        step(); chk("prox_nota", db_estado, 6); chk("en_jogada_nota", enable_contador_jogada, 1);
        muda_nota = 1'b0;
        step(); chk("toca3", db_estado, 5);
        enderecoIgualLimite = 1'b1; muda_nota = 1'b1;
        step(); chk("fim_mostra2", db_estado, 7);
        muda_nota = 1'b0; enderecoIgualLimite = 1'b0;
        step(); chk("espera2", db_estado, 8);
        tem_jogada = 1'b1; step(); tem_jogada = 1'b0;
        step(); chk("compara2", db_estado, 10);
        step(); chk("prox_jogada", db_estado, 11); chk("en_jogada", enable_contador_jogada, 1);
        step(); chk("espera3", db_estado, 8);
        botoesIgualMemoria = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tem_jogada = 1'b1; step(); tem_jogada = 1'b0;
            step(); chk("compara_err", db_estado, 10);
            step(); chk("erro", db_estado, 12); chk("contaErro", contaErro, 1);
            step(); chk("apos_erro", db_estado, (k == 2) ? 15 : 8); chk("contaErro_off", contaErro, 0);
        end
        chk("mostraB_fim", mostraB, 1);
        step(); chk("fim_jogo_hold", db_estado, 15);
        iniciar = 1'b1;
        step(); chk("reinicio", db_estado, 0); chk("zeraPontos", zeraPontos, 1);
        step(); chk("mensagem2", db_estado, 1);
        iniciar = 1'b0;

        // Second game: last round matched with fimL
        tem_jogada = 1'b1; step(); tem_jogada = 1'b0;
        step(); step(); chk("toca4", db_estado, 5);
        enderecoIgualLimite = 1'b1; muda_nota = 1'b1;
        step(); muda_nota = 1'b0;
        step(); chk("espera4", db_estado, 8);
        tem_jogada = 1'b1; botoesIgualMemoria = 1'b1; step(); tem_jogada = 1'b0;
        step(); fimL = 1'b1;
        step(); chk("fim_rodada2", db_estado, 13);
        step(); chk("fim_jogo_fimL", db_estado, 15);
        fimL = 1'b0; iniciar = 1'b1;
        step(); chk("inicial3", db_estado, 0); chk("zeraPontos2", zeraPontos, 1);
        step(); iniciar = 1'b0;

        // Asynchronous reset while playing a note
        tem_jogada = 1'b1; step(); tem_jogada = 1'b0;
        step(); step(); chk("toca5", db_estado, 5);
        #2 reset = 1'b1;
        #1;
        chk("async_estado", db_estado, 0); chk("async_display", contagem_display, 0);
        chk("async_zera_rodada", zera_contador_rodada, 1); chk("async_mostraJ", mostraJ, 0);
        reset = 1'b0; enderecoIgualLimite = 1'b0; botoesIgualMemoria = 1'b0;
        step(); step(); step(); chk("display_0", contagem_display, 0);
        step(); chk("display_1", contagem_display, 1); chk("inicial_hold", db_estado, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
